// File: rtl/softplus_arbiter.sv
// Round-robin front end that time-shares one combinational Softplus datapath
// between NUM_REQ requesters, with operand and result register stages.
module softplus_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  resp_valid,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_data,
    input  logic                  resp_ready,
    output logic                  busy,
    output logic [CNT_W-1:0]      done_count
);

    logic [ID_W-1:0] rr_ptr;
    logic            s1_v;
    logic [ID_W-1:0] s1_id;
    logic [31:0]     s1_data;
    logic            s2_v;
    logic [ID_W-1:0] s2_id;
    logic [31:0]     s2_data;

    logic            s1_free;
    logic            s2_free;
    logic            any_valid;
    logic            accept;
    logic            found;
    logic [ID_W:0]   idx;
    logic [ID_W-1:0] grant_id;
    logic [31:0]     req_word [NUM_REQ];
    logic [31:0]     op_sel;
    logic [31:0]     sp_result;

    assign s2_free   = !s2_v || resp_ready;
    assign s1_free   = !s1_v || s2_free;
    assign any_valid = |req_valid;
    assign accept    = any_valid && s1_free;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign req_word[gi]  = req_data[32*gi +: 32];
        assign req_ready[gi] = rst_n && accept && (grant_id == ID_W'(gi));
    end

    // First valid requester at or after rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQ)) begin
                idx = idx - (ID_W+1)'(NUM_REQ);
            end
            if (!found && req_valid[idx[ID_W-1:0]]) begin
                found    = 1'b1;
                grant_id = idx[ID_W-1:0];
            end
        end
    end

    assign op_sel = req_word[grant_id];

    // Softplus sampled every 0.25 over [-2, 3], unsigned Q2.16.
    function automatic logic [17:0] sp_lut(input logic [4:0] k);
        case (k)
            5'd0:    sp_lut = 18'd8318;
            5'd1:    sp_lut = 18'd10501;
            5'd2:    sp_lut = 18'd13200;
            5'd3:    sp_lut = 18'd16510;
            5'd4:    sp_lut = 18'd20530;
            5'd5:    sp_lut = 18'd25354;
            5'd6:    sp_lut = 18'd31069;
            5'd7:    sp_lut = 18'd37745;
            5'd8:    sp_lut = 18'd45426;
            5'd9:    sp_lut = 18'd54130;
            5'd10:   sp_lut = 18'd63837;
            5'd11:   sp_lut = 18'd74506;
            5'd12:   sp_lut = 18'd86066;
            5'd13:   sp_lut = 18'd98430;
            5'd14:   sp_lut = 18'd111504;
            5'd15:   sp_lut = 18'd125189;
            5'd16:   sp_lut = 18'd139390;
            5'd17:   sp_lut = 18'd154023;
            5'd18:   sp_lut = 18'd169010;
            5'd19:   sp_lut = 18'd184285;
            default: sp_lut = 18'd199792;
        endcase
    endfunction

    logic        x_sgn;
    logic [7:0]  x_exp;
    logic [23:0] x_man;
    logic        x_nan;
    logic        x_gt3;
    logic        x_ltm2;
    logic [7:0]  shamt;
    logic [18:0] mag;
    logic [18:0] u_pos;
    logic [4:0]  seg;
    logic [4:0]  seg_next;
    logic [13:0] frac;
    logic [17:0] t0;
    logic [17:0] t1;
    logic [13:0] diff;
    logic [27:0] prod;
    logic [17:0] y;
    logic [4:0]  lead;
    logic [23:0] norm;
    logic [31:0] approx;

    assign x_sgn  = s1_data[31];
    assign x_exp  = s1_data[30:23];
    assign x_man  = {1'b1, s1_data[22:0]};
    assign x_nan  = (x_exp == 8'hFF) && (s1_data[22:0] != 23'd0);
    assign x_gt3  = !x_sgn && (s1_data[30:0] > 31'h4040_0000) && !x_nan;
    assign x_ltm2 = x_sgn && (s1_data[30:0] > 31'h4000_0000) && !x_nan;
    assign shamt  = 8'd134 - x_exp;

    always_comb begin
        mag = '0;
        if (x_exp >= 8'd111 && x_exp <= 8'd133) begin
            mag = 19'(x_man >> shamt);
        end
    end

    // Offset by +2.0 so the segment index is a plain bit slice.
    assign u_pos    = x_sgn ? (19'd131072 - mag) : (19'd131072 + mag);
    assign seg      = u_pos[18:14];
    assign frac     = u_pos[13:0];
    assign seg_next = (seg >= 5'd20) ? 5'd20 : seg + 5'd1;
    assign t0       = sp_lut(seg);
    assign t1       = sp_lut(seg_next);
    assign diff     = 14'(t1 - t0);
    assign prod     = diff * frac;
    assign y        = t0 + 18'(prod >> 14);

    always_comb begin
        lead = '0;
        for (int b = 0; b < 18; b++) begin
            if (y[b]) begin
                lead = 5'(b);
            end
        end
    end

    assign norm   = {y, 6'd0} << (5'd17 - lead);
    assign approx = {1'b0, 8'(lead) + 8'd111, 23'(norm)};

    always_comb begin
        sp_result = approx;
        if (x_nan) begin
            sp_result = 32'h7FC0_0000;
        end else if (x_gt3) begin
            sp_result = s1_data;
        end else if (x_ltm2) begin
            sp_result = 32'h0000_0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            s1_v       <= 1'b0;
            s1_id      <= '0;
            s1_data    <= '0;
            s2_v       <= 1'b0;
            s2_id      <= '0;
            s2_data    <= '0;
            done_count <= '0;
        end else begin
            if (accept) begin
                s1_id   <= grant_id;
                s1_data <= op_sel;
                if (grant_id == ID_W'(NUM_REQ - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant_id + 1'b1;
                end
            end
            if (s1_free) begin
                s1_v <= accept;
            end
            if (s2_free) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_id   <= s1_id;
                    s2_data <= sp_result;
                end
            end
            if (s2_v && resp_ready) begin
                done_count <= done_count + 1'b1;
            end
        end
    end

    assign resp_valid = s2_v;
    assign resp_id    = s2_id;
    assign resp_data  = s2_data;
    assign busy       = s1_v || s2_v;

endmodule

// File: tb/tb_softplus_arbiter.sv
// Scoreboard bench for softplus_arbiter: a queue-based pipeline/arbiter model
// predicts grants, and results are judged against real-valued Softplus.
module tb_softplus_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid;
    logic [31:0]      ops [N];
    logic [32*N-1:0]  req_data;
    logic             resp_ready;

    logic [N-1:0]     req_ready,  req_ready4;
    logic             resp_valid, resp_valid4;
    logic [IDW-1:0]   resp_id,    resp_id4;
    logic [31:0]      resp_data,  resp_data4;
    logic             busy,       busy4;
    logic [15:0]      done_count;
    logic [3:0]       done_count4;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign req_data[32*gi +: 32] = ops[gi];
    end

    softplus_arbiter #(.NUM_REQ(N), .ID_W(IDW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_data(resp_data), .resp_ready(resp_ready), .busy(busy),
        .done_count(done_count)
    );

    softplus_arbiter #(.NUM_REQ(N), .ID_W(IDW), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready4), .resp_valid(resp_valid4), .resp_id(resp_id4),
        .resp_data(resp_data4), .resp_ready(resp_ready), .busy(busy4),
        .done_count(done_count4)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [31:0]    op;
    } item_t;

    item_t sbq [$];
    int    checks = 0;
    int    errors = 0;
    logic [N-1:0] got;

    task automatic chk(input bit ok, input string name, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic real f2r(input logic [31:0] b);
        logic [10:0] e11;
        if (b[30:23] == 8'd0) return 0.0;
        if (b[30:23] == 8'hFF) return b[31] ? -1.0e300 : 1.0e300;
        e11 = 11'(b[30:23]) + 11'd896;
        return $bitstoreal({b[31], e11, b[22:0], 29'd0});
    endfunction

    task automatic check_result(input item_t it, input logic [IDW-1:0] id,
                                input logic [31:0] d, input string tag);
        real x, r, ref_v, err;
        chk(id == it.id, {tag, "_id"}, $sformatf("got %0d expected %0d", id, it.id));
        x = f2r(it.op);
        if (x > 3.0) begin
            chk(d == it.op, {tag, "_pass"}, $sformatf("op %h got %h expected %h", it.op, d, it.op));
        end else if (x < -2.0) begin
            chk(d == 32'd0, {tag, "_clamp"}, $sformatf("op %h got %h expected 00000000", it.op, d));
        end else begin
            r     = f2r(d);
            ref_v = $ln(1.0 + $exp(x));
            err   = (r > ref_v) ? r - ref_v : ref_v - r;
            chk(!d[31] && err <= 0.005, {tag, "_approx"},
                $sformatf("op %h got %h (%f) expected %f", it.op, d, r, ref_v));
        end
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        case ($urandom_range(0, 11))
            0:  v = 32'h4040_0000;
            1:  v = 32'hC000_0000;
            2:  v = 32'h4040_0001;
            3:  v = 32'hC000_0001;
            default: v = {1'($urandom_range(0, 1)), 8'($urandom_range(118, 130)), 23'($urandom)};
        endcase
        return v;
    endfunction

    // Predictor: round-robin grant and two-slot occupancy, pushes accepted items.
    int           p_rr = 0;
    int           p_cnt = 0;
    int           p_g;
    bit           p_found;
    logic [N-1:0] p_rdy;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_rr  = 0;
                p_cnt = 0;
                sbq.delete();
            end else begin
                p_found = 1'b0;
                p_g     = 0;
                for (int k = 0; k < N; k++) begin
                    if (!p_found && req_valid[(p_rr + k) % N]) begin
                        p_found = 1'b1;
                        p_g     = (p_rr + k) % N;
                    end
                end
                p_rdy = (p_found && !(p_cnt == 2 && !resp_ready)) ? (N'(1) << p_g) : '0;
                chk(req_ready == p_rdy, "req_ready", $sformatf("got %b expected %b", req_ready, p_rdy));
                chk(req_ready4 == p_rdy, "req_ready_w4", $sformatf("got %b expected %b", req_ready4, p_rdy));
                chk(busy == (p_cnt != 0), "busy", $sformatf("got %b expected %b", busy, p_cnt != 0));
                chk(busy4 == (p_cnt != 0), "busy_w4", $sformatf("got %b expected %b", busy4, p_cnt != 0));
                if (p_rdy != '0) begin
                    sbq.push_back(item_t'{id: IDW'(p_g), op: ops[p_g]});
                    p_rr = (p_g + 1) % N;
                    p_cnt++;
                end
                if (resp_valid && resp_ready) p_cnt--;
            end
        end
    end

    // Monitor: pops on every response handshake and checks hold/counter rules.
    int             m_hs = 0;
    bit             m_stall = 1'b0;
    logic [IDW-1:0] m_id;
    logic [31:0]    m_data;
    item_t          m_it;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_hs    = 0;
                m_stall = 1'b0;
            end else begin
                chk(done_count == 16'(m_hs), "done_count", $sformatf("got %0d expected %0d", done_count, 16'(m_hs)));
                chk(done_count4 == 4'(m_hs), "done_count_w4", $sformatf("got %0d expected %0d", done_count4, 4'(m_hs)));
                if (m_stall) begin
                    chk(resp_valid && resp_id == m_id && resp_data == m_data, "resp_hold",
                        $sformatf("got v=%b id=%0d d=%h expected v=1 id=%0d d=%h",
                                  resp_valid, resp_id, resp_data, m_id, m_data));
                end
                if (resp_valid && resp_ready) begin
                    if (sbq.size() == 0) begin
                        chk(1'b0, "unexpected_resp", $sformatf("got id=%0d d=%h expected none", resp_id, resp_data));
                    end else begin
                        m_it = sbq.pop_front();
                        $display("resp id=%0d op=%h data=%h", resp_id, m_it.op, resp_data);
                        check_result(m_it, resp_id, resp_data, "resp");
                        chk(resp_valid4, "resp_valid_w4", "got 0 expected 1");
                        check_result(m_it, resp_id4, resp_data4, "resp_w4");
                    end
                    m_hs++;
                end
                m_stall = resp_valid && !resp_ready;
                m_id    = resp_id;
                m_data  = resp_data;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        got = req_ready;
        @(posedge clk);
        #1;
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic refill();
        for (int i = 0; i < N; i++) if (got[i]) ops[i] = rand_op();
    endtask

    int g0;
    int acc;
    logic [31:0] bvals [12] = '{32'h4040_0000, 32'hC000_0000, 32'h4040_0001, 32'hC000_0001,
                               32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                               32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 32'h3E80_0000};

    initial begin
        req_valid  = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < N; i++) ops[i] = 32'd0;

        // Reset state, with requests pending to show req_ready stays low.
        req_valid = '1;
        #2;
        chk(req_ready == '0 && resp_valid == 1'b0 && resp_id == '0 && resp_data == 32'd0 &&
            busy == 1'b0 && done_count == 16'd0, "reset_state",
            $sformatf("got rdy=%b v=%b id=%0d d=%h busy=%b cnt=%0d expected all zero",
                      req_ready, resp_valid, resp_id, resp_data, busy, done_count));
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request: 5.0 passes through, visible two edges after launch.
        ops[0] = 32'h40A0_0000;
        req_valid = 4'b0001;
        step();
        chk(got == 4'b0001, "single_grant", $sformatf("got %b expected 0001", got));
        req_valid = '0;
        @(negedge clk);
        chk(!resp_valid, "latency_s1", $sformatf("got %b expected 0", resp_valid));
        @(negedge clk);
        chk(resp_valid && resp_id == 2'd0 && resp_data == 32'h40A0_0000, "latency_s2",
            $sformatf("got v=%b id=%0d d=%h expected v=1 id=0 d=40a00000", resp_valid, resp_id, resp_data));
        @(posedge clk);
        #1;
        chk(done_count == 16'd1, "single_count", $sformatf("got %0d expected 1", done_count));

        // Negative clamp on requester 2.
        ops[2] = 32'hC080_0000;
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        repeat (3) step();

        // Round-robin with everyone requesting.
        for (int i = 0; i < N; i++) ops[i] = rand_op();
        req_valid = '1;
        g0 = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (c == 0) g0 = onehot_idx(got);
            else chk(onehot_idx(got) == (g0 + c) % N, "rr_order",
                     $sformatf("got %0d expected %0d", onehot_idx(got), (g0 + c) % N));
            if (c >= 1) chk(resp_valid, "rr_throughput", "got 0 expected 1");
            refill();
        end
        req_valid = '0;
        repeat (3) step();

        // Backpressure: two operands fill the pipe, then nothing more.
        resp_ready = 1'b0;
        req_valid  = 4'b0011;
        acc = 0;
        repeat (5) begin
            step();
            if (got != '0) acc++;
            refill();
        end
        chk(acc == 2, "bp_accepts", $sformatf("got %0d expected 2", acc));
        resp_ready = 1'b1;
        repeat (4) begin
            step();
            refill();
        end
        req_valid = '0;
        repeat (3) step();

        // Threshold and special operands on requester 3.
        for (int v = 0; v < 12; v++) begin
            ops[3] = bvals[v];
            req_valid = 4'b1000;
            resp_ready = 1'($urandom_range(0, 1));
            for (int t = 0; t < 10; t++) begin
                step();
                resp_ready = 1'b1;
                if (got[3]) break;
            end
            chk(got[3], "boundary_grant", $sformatf("got %b expected 1000", got));
            req_valid = '0;
        end
        repeat (3) step();

        // Asynchronous reset with both stages full.
        resp_ready = 1'b0;
        req_valid  = 4'b0011;
        repeat (4) begin
            step();
            refill();
        end
        #3 rst_n = 1'b0;
        #1;
        chk(!resp_valid && !busy && done_count == 16'd0 && done_count4 == 4'd0 && req_ready == '0,
            "async_reset", $sformatf("got v=%b busy=%b cnt=%0d cnt4=%0d rdy=%b expected all zero",
                                     resp_valid, busy, done_count, done_count4, req_ready));
        req_valid = '1;
        step();
        @(posedge clk);
        #1 rst_n = 1'b1;
        resp_ready = 1'b1;

        // Seventeen back-to-back handshakes wrap the 4-bit counter to 1.
        for (int c = 0; c < 17; c++) begin
            step();
            if (c == 0) chk(got == 4'b0001, "grant_after_reset", $sformatf("got %b expected 0001", got));
            refill();
        end
        req_valid = '0;
        repeat (4) step();
        chk(done_count4 == 4'd1 && done_count == 16'd17, "wrap17",
            $sformatf("got cnt4=%0d cnt=%0d expected 1 and 17", done_count4, done_count));

        // Random traffic: requesters may hold, drop or renew; random backpressure.
        for (int i = 0; i < N; i++) ops[i] = rand_op();
        for (int c = 0; c < 700; c++) begin
            for (int i = 0; i < N; i++) begin
                if (got[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    ops[i] = rand_op();
                end else if ($urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        req_valid  = '0;
        resp_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (sbq.size() == 0 && !busy) break;
            step();
        end
        chk(sbq.size() == 0 && !busy, "drain", $sformatf("got %0d pending busy=%b expected 0", sbq.size(), busy));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
